// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge.
//   htrans_t : AHB transfer type encodings
//   hresp_t  : AHB response codes used by the bridge (OKAY, ERROR)
//   state_t  : bridge FSM states
//   idx_width: width of a slave index for a given slave count (min 1)
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// Address decoder for the APB segment.
//   haddr    : AHB address-phase address
//   in_range : address falls inside BASE_ADDR .. BASE_ADDR + (NUM_SLV << WIN_LOG2) - 1
//   sel      : one-hot slave select (all zero when out of range)
module ahb_apb_decoder
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_SLV   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int                WIN_LOG2  = 12
)(
    input  logic [ADDR_W-1:0]  haddr,
    output logic               in_range,
    output logic [NUM_SLV-1:0] sel
);

    localparam int IDX_W = idx_width(NUM_SLV);
    // One extra bit so BASE_ADDR + span cannot wrap at the top of the map.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_SLV) << WIN_LOG2;

    logic [IDX_W-1:0] idx;

    assign in_range = ({1'b0, haddr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, haddr} <  ({1'b0, BASE_ADDR} + SPAN));
    assign idx      = IDX_W'((haddr - BASE_ADDR) >> WIN_LOG2);

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
            assign sel[gi] = in_range && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/ahb_apb_bridge_gen.sv
// AHB slave to NUM_SLV-way APB bridge with wait states, error mapping and timeout.
//   AHB side : Hready_in, Htrans, Hwrite, Haddr, Hwdata -> Hready_out, Hresp, Hrdata
//   APB side : Pselx (one-hot), Penable, Pwrite, Paddr, Pwdata -> Prdata, Pready, Pslverr
// APB outputs are registered; Hready_out/Hresp/Hrdata follow the state register
// except in ACCESS, where they pass the selected slave's Pready/Pslverr/Prdata through.
module ahb_apb_bridge_gen
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int                WIN_LOG2  = 12,
    parameter int                TIMEOUT   = 16
)(
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic                      Hready_in,
    input  logic [1:0]                Htrans,
    input  logic                      Hwrite,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         Hwdata,
    output logic                      Hready_out,
    output logic [1:0]                Hresp,
    output logic [DATA_W-1:0]         Hrdata,
    output logic [NUM_SLV-1:0]        Pselx,
    output logic                      Penable,
    output logic                      Pwrite,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         Pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] Prdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              state_reg, state_next;
    logic [NUM_SLV-1:0]  sel_reg, sel_next;
    logic [NUM_SLV-1:0]  psel_reg, psel_next;
    logic                penable_reg, penable_next;
    logic                pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0]   paddr_reg, paddr_next;
    logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic                dec_in_range;
    logic [NUM_SLV-1:0]  dec_sel;
    logic                pready_sel, pslverr_sel, timeout_hit, access_ok, sample, accept;
    logic [DATA_W-1:0]   rd_terms [NUM_SLV];
    logic [DATA_W-1:0]   rd_sel;

    ahb_apb_decoder #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .WIN_LOG2  (WIN_LOG2)
    ) u_dec (
        .haddr    (Haddr),
        .in_range (dec_in_range),
        .sel      (dec_sel)
    );

    // Masking with the registered one-hot select makes unselected slaves invisible.
    assign pready_sel  = |(Pready  & psel_reg);
    assign pslverr_sel = |(Pslverr & psel_reg);

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rd
            assign rd_terms[gi] = psel_reg[gi] ? Prdata[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            rd_sel = rd_sel | rd_terms[i];
        end
    end

    // cnt_reg counts completed ACCESS cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign access_ok   = (state_reg == ST_ACCESS) && pready_sel && !pslverr_sel;
    // A new address phase is only looked at while the bridge drives Hready_out high.
    assign sample      = (state_reg == ST_IDLE) || (state_reg == ST_ERR2) || access_ok;
    assign accept      = sample && Hready_in &&
                         ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        pwrite_next = pwrite_reg;
        paddr_next  = paddr_reg;
        pwdata_next = pwdata_reg;
        Hready_out  = 1'b1;
        Hresp       = HRESP_OKAY;
        Hrdata      = '0;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            ST_WLATCH: begin
                Hready_out  = 1'b0;
                pwdata_next = Hwdata;
                state_next  = ST_SETUP;
            end
            ST_SETUP: begin
                Hready_out = 1'b0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                Hready_out = access_ok;
                if (pready_sel) begin
                    if (pslverr_sel) begin
                        state_next = ST_ERR1;
                    end else begin
                        if (!pwrite_reg) begin
                            Hrdata = rd_sel;
                        end
                        state_next = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ERR1;
                end
            end
            ST_ERR1: begin
                Hready_out = 1'b0;
                Hresp      = HRESP_ERROR;
                state_next = ST_ERR2;
            end
            ST_ERR2: begin
                Hresp      = HRESP_ERROR;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (accept) begin
            if (dec_in_range) begin
                sel_next    = dec_sel;
                pwrite_next = Hwrite;
                paddr_next  = Haddr;
                state_next  = Hwrite ? ST_WLATCH : ST_SETUP;
            end else begin
                state_next  = ST_ERR1;
            end
        end
    end

    always_comb begin
        psel_next    = ((state_next == ST_SETUP) || (state_next == ST_ACCESS)) ? sel_next : '0;
        penable_next = (state_next == ST_ACCESS);
        cnt_next     = ((state_reg == ST_ACCESS) && (state_next == ST_ACCESS)) ?
                       cnt_reg + 1'b1 : '0;
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            psel_reg    <= psel_next;
            penable_reg <= penable_next;
            pwrite_reg  <= pwrite_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign Pselx   = psel_reg;
    assign Penable = penable_reg;
    assign Pwrite  = pwrite_reg;
    assign Paddr   = paddr_reg;
    assign Pwdata  = pwdata_reg;

endmodule

// File: tb/tb_ahb_apb_bridge_gen.sv
module tb_ahb_apb_bridge_gen;
    import ahb_apb_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          NUM_SLV  = 4;
    localparam int          WIN_LOG2 = 12;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] BASE     = 32'h8000_0000;

    logic                      Hclk = 1'b0;
    logic                      Hreset = 1'b1;
    logic                      Hready_in = 1'b1;
    logic [1:0]                Htrans = 2'b00;
    logic                      Hwrite = 1'b0;
    logic [ADDR_W-1:0]         Haddr = '0;
    logic [DATA_W-1:0]         Hwdata = '0;
    logic                      Hready_out;
    logic [1:0]                Hresp;
    logic [DATA_W-1:0]         Hrdata;
    logic [NUM_SLV-1:0]        Pselx;
    logic                      Penable;
    logic                      Pwrite;
    logic [ADDR_W-1:0]         Paddr;
    logic [DATA_W-1:0]         Pwdata;
    logic [NUM_SLV*DATA_W-1:0] Prdata = '0;
    logic [NUM_SLV-1:0]        Pready = '0;
    logic [NUM_SLV-1:0]        Pslverr = '0;

    ahb_apb_bridge_gen #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .NUM_SLV (NUM_SLV),
        .BASE_ADDR (BASE), .WIN_LOG2 (WIN_LOG2), .TIMEOUT (TIMEOUT)
    ) dut (
        .Hclk (Hclk), .Hreset (Hreset), .Hready_in (Hready_in), .Htrans (Htrans),
        .Hwrite (Hwrite), .Haddr (Haddr), .Hwdata (Hwdata),
        .Hready_out (Hready_out), .Hresp (Hresp), .Hrdata (Hrdata),
        .Pselx (Pselx), .Penable (Penable), .Pwrite (Pwrite), .Paddr (Paddr),
        .Pwdata (Pwdata), .Prdata (Prdata), .Pready (Pready), .Pslverr (Pslverr)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        logic [31:0] addr;
        bit          write;
        logic [31:0] wdata;
        int          waits;   // Pready low cycles in ACCESS before ready
        bit          err;     // Pslverr at ready
        bit          seq;
    } txn_t;

    int checks = 0;
    int failures = 0;
    int obs_done;             // first cycle after address phase with Hready_out=1
    logic [3:0] obs_psel;     // Pselx seen in SETUP
    logic [1:0] obs_resp;     // Hresp on obs_done cycle

    txn_t q[$];
    int   gaps[$];
    int   done_log[$];
    logic [3:0] psel_log[$];
    logic [1:0] resp_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned la = a;
        longint unsigned lb = BASE;
        return (la >= lb) && (la < lb + longint'(NUM_SLV) * (64'd1 << WIN_LOG2));
    endfunction

    function automatic txn_t mk(input logic [31:0] a, input bit w, input logic [31:0] d,
                                input int wt, input bit e, input bit s);
        txn_t t;
        t.addr = a; t.write = w; t.wdata = d; t.waits = wt; t.err = e; t.seq = s;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int r = $urandom_range(0, 9);
        if (r < 7)       t.addr = BASE + 32'($urandom_range(0, NUM_SLV-1)) * 32'h1000
                                   + 32'($urandom_range(0, 1023)) * 4;
        else if (r == 7) t.addr = BASE + 32'h4000 + 32'($urandom_range(0, 255)) * 4;
        else if (r == 8) t.addr = BASE - 32'($urandom_range(1, 100)) * 4;
        else             t.addr = $urandom & 32'h7FFF_FFFC;
        t.write = 1'($urandom);
        t.wdata = $urandom;
        t.waits = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 2) == 0) ? 15 :
                  ($urandom_range(0, 1) == 0) ? 16 : 20) : $urandom_range(0, 3);
        t.err   = ($urandom_range(0, 4) == 0);
        t.seq   = 1'($urandom);
        return t;
    endfunction

    task automatic rand_apb();
        for (int s = 0; s < NUM_SLV; s++) Prdata[s*DATA_W +: DATA_W] = $urandom;
        Pready  = 4'($urandom);
        Pslverr = 4'($urandom);
    endtask

    task automatic drive_addr(input txn_t t, input bit valid);
        if (valid) begin
            Htrans = t.seq ? HTRANS_SEQ : HTRANS_NONSEQ;
            Haddr  = t.addr;
            Hwrite = t.write;
        end else begin
            Htrans = 2'($urandom_range(0, 1));
            Haddr  = $urandom;
            Hwrite = 1'($urandom);
        end
    endtask

    // Bus idle cycle (bridge idle); optionally presents an address phase.
    task automatic idle_cycle(input bit valid, input txn_t t);
        @(negedge Hclk);
        Hready_in = 1'b1;
        drive_addr(t, valid);
        rand_apb();
        Hwdata = $urandom;
        #1;
        chk("idle_hready", 64'(Hready_out), 64'd1);
        chk("idle_hresp",  64'(Hresp), 64'd0);
        chk("idle_psel",   64'(Pselx), 64'd0);
        chk("idle_penable",64'(Penable), 64'd0);
        chk("idle_hrdata", 64'(Hrdata), 64'd0);
    endtask

    // Runs one transaction whose address phase was presented on the previous cycle.
    // Expected per-cycle behaviour is derived from the transaction shape:
    // [WLATCH] SETUP ACCESS x n [ERR1 ERR2], or ERR1 ERR2 when out of range.
    task automatic run_txn(input txn_t t, input bit nv, input txn_t n);
        bit inr = in_range(t.addr);
        int idx = 0, setup_k = 0, acc_len = 0, total, err1_k;
        bit ok = 1'b0, ready_seen;
        logic [3:0] onehot = '0;
        if (inr) begin
            idx     = int'((t.addr - BASE) >> WIN_LOG2);
            onehot  = 4'b0001 << idx;
            setup_k = t.write ? 2 : 1;
            ready_seen = (t.waits + 1 <= TIMEOUT);
            acc_len = ready_seen ? t.waits + 1 : TIMEOUT;
            ok      = ready_seen && !t.err;
            err1_k  = setup_k + acc_len + 1;
            total   = ok ? setup_k + acc_len : setup_k + acc_len + 2;
        end else begin
            ready_seen = 1'b0;
            err1_k = 1;
            total  = 2;
        end
        obs_done = 0; obs_psel = 'x; obs_resp = 'x;
        for (int k = 1; k <= total; k++) begin
            bit last = (k == total);
            bit in_acc = inr && (k > setup_k) && (k <= setup_k + acc_len);
            int j = k - setup_k;
            logic       e_hrdy, e_pen;
            logic [1:0] e_resp;
            logic [3:0] e_psel;
            logic [31:0] e_rd;
            @(negedge Hclk);
            rand_apb();
            Hwdata = (t.write && k == 1) ? t.wdata : $urandom;
            Hready_in = last;
            if (last) drive_addr(n, nv);
            else begin
                drive_addr(n, 1'b0);
                Htrans = 2'($urandom);
            end
            if (in_acc) begin
                if (j == acc_len && ready_seen) begin
                    Pready[idx] = 1'b1; Pslverr[idx] = t.err;
                end else begin
                    Pready[idx] = 1'b0; Pslverr[idx] = 1'b0;
                end
            end
            #1;
            e_hrdy = 1'b0; e_resp = 2'b00; e_psel = '0; e_pen = 1'b0; e_rd = '0;
            if (!ok && k >= err1_k) begin
                e_hrdy = (k != err1_k);
                e_resp = 2'b01;
            end else if (inr && k == setup_k) begin
                e_psel = onehot;
            end else if (in_acc) begin
                e_psel = onehot;
                e_pen  = 1'b1;
                if (j == acc_len && ok) begin
                    e_hrdy = 1'b1;
                    if (!t.write) e_rd = Prdata[idx*DATA_W +: DATA_W];
                end
            end
            chk("hready_out", 64'(Hready_out), 64'(e_hrdy));
            chk("hresp",      64'(Hresp), 64'(e_resp));
            chk("pselx",      64'(Pselx), 64'(e_psel));
            chk("penable",    64'(Penable), 64'(e_pen));
            chk("hrdata",     64'(Hrdata), 64'(e_rd));
            if (inr && (k == setup_k || in_acc)) begin
                chk("paddr",  64'(Paddr), 64'(t.addr));
                chk("pwrite", 64'(Pwrite), 64'(t.write));
                if (t.write) chk("pwdata", 64'(Pwdata), 64'(t.wdata));
            end
            if (inr && k == setup_k) obs_psel = Pselx;
            if (Hready_out && obs_done == 0) begin
                obs_done = k;
                obs_resp = Hresp;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pending;
        txn_t dummy;
        dummy = mk(32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge Hclk);
        #1;
        chk("rst_hready",  64'(Hready_out), 64'd1);
        chk("rst_hresp",   64'(Hresp), 64'd0);
        chk("rst_hrdata",  64'(Hrdata), 64'd0);
        chk("rst_psel",    64'(Pselx), 64'd0);
        chk("rst_penable", 64'(Penable), 64'd0);
        chk("rst_pwrite",  64'(Pwrite), 64'd0);
        chk("rst_paddr",   64'(Paddr), 64'd0);
        chk("rst_pwdata",  64'(Pwdata), 64'd0);
        @(negedge Hclk);
        Hreset = 1'b0;

        // Directed transactions (gap 0 = address phase in previous transaction's last cycle)
        q.push_back(mk(32'h8000_1004, 0, 32'h0,         0,  0, 0)); gaps.push_back(1);
        q.push_back(mk(32'h8000_3000, 1, 32'hDEAD_BEEF, 2,  0, 0)); gaps.push_back(1);
        q.push_back(mk(32'h7000_0000, 0, 32'h0,         0,  0, 0)); gaps.push_back(1);
        q.push_back(mk(32'h8000_2010, 1, 32'h1234_5678, 0,  1, 0)); gaps.push_back(1);
        q.push_back(mk(32'h8000_2014, 0, 32'h0,         1,  0, 1)); gaps.push_back(0);
        q.push_back(mk(32'h8000_0100, 0, 32'h0,         20, 0, 0)); gaps.push_back(1);
        q.push_back(mk(32'h8000_1000, 0, 32'h0,         15, 0, 0)); gaps.push_back(1);
        q.push_back(mk(32'h8000_0000, 0, 32'h0,         0,  0, 0)); gaps.push_back(1);
        q.push_back(mk(32'h8000_1000, 0, 32'h0,         0,  0, 1)); gaps.push_back(0);
        q.push_back(mk(32'h8000_2000, 0, 32'h0,         0,  0, 1)); gaps.push_back(0);
        q.push_back(mk(32'h8000_3FFC, 0, 32'h0,         0,  0, 1)); gaps.push_back(0);
        q.push_back(mk(32'h8000_4000, 0, 32'h0,         0,  0, 0)); gaps.push_back(0);
        for (int i = 0; i < 60; i++) begin
            q.push_back(rand_txn());
            gaps.push_back($urandom_range(0, 2));
        end

        pending = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            bit nv;
            if (!pending) begin
                int g = (gaps[i] == 0) ? 1 : gaps[i];
                for (int c = 0; c < g; c++) idle_cycle(c == g - 1, q[i]);
            end
            nv = (i + 1 < q.size()) && (gaps[i+1] == 0);
            run_txn(q[i], nv, nv ? q[i+1] : dummy);
            pending = nv;
            done_log.push_back(obs_done);
            psel_log.push_back(obs_psel);
            resp_log.push_back(obs_resp);
            $display("txn %0d addr=%h write=%0b waits=%0d err=%0b ready_cycle=%0d resp=%0h",
                     i, q[i].addr, q[i].write, q[i].waits, q[i].err, obs_done, obs_resp);
        end

        // Hand-computed pins (cycle index after the address phase, 1-based)
        chk("pin_rd1_psel",   64'(psel_log[0]), 64'(4'b0010));
        chk("pin_rd1_ready",  64'(done_log[0]), 64'd2);
        chk("pin_rd1_resp",   64'(resp_log[0]), 64'd0);
        chk("pin_wr3_psel",   64'(psel_log[1]), 64'(4'b1000));
        chk("pin_wr3_ready",  64'(done_log[1]), 64'd5);
        chk("pin_oor_ready",  64'(done_log[2]), 64'd2);
        chk("pin_oor_resp",   64'(resp_log[2]), 64'd1);
        chk("pin_slverr_rdy", 64'(done_log[3]), 64'd5);
        chk("pin_slverr_rsp", 64'(resp_log[3]), 64'd1);
        chk("pin_err2_seq",   64'(resp_log[4]), 64'd0);
        chk("pin_tmo_ready",  64'(done_log[5]), 64'd19);
        chk("pin_tmo_resp",   64'(resp_log[5]), 64'd1);
        chk("pin_tmo16_rdy",  64'(done_log[6]), 64'd17);
        chk("pin_tmo16_resp", 64'(resp_log[6]), 64'd0);
        chk("pin_b2b_psel3",  64'(psel_log[10]), 64'(4'b1000));
        chk("pin_edge_resp",  64'(resp_log[11]), 64'd1);

        // Reset in the middle of ACCESS
        if (pending) begin
            @(negedge Hclk);
            Hready_in = 1'b1; Htrans = HTRANS_IDLE;
            #1;
        end
        idle_cycle(1'b1, mk(32'h8000_1008, 0, 32'h0, 30, 0, 0));
        @(negedge Hclk);
        Hready_in = 1'b0; Htrans = HTRANS_IDLE; Pready = '0; Pslverr = '0;
        @(negedge Hclk);
        Pready = '0; Pslverr = '0;
        #1;
        chk("mid_penable", 64'(Penable), 64'd1);
        Hreset = 1'b1;
        #1;
        chk("arst_psel",    64'(Pselx), 64'd0);
        chk("arst_penable", 64'(Penable), 64'd0);
        chk("arst_hready",  64'(Hready_out), 64'd1);
        chk("arst_hresp",   64'(Hresp), 64'd0);
        chk("arst_paddr",   64'(Paddr), 64'd0);
        @(negedge Hclk);
        Hreset = 1'b0; Hready_in = 1'b1;
        idle_cycle(1'b1, mk(32'h8000_2008, 0, 32'h0, 1, 0, 0));
        run_txn(mk(32'h8000_2008, 0, 32'h0, 1, 0, 0), 1'b0, dummy);
        $display("txn post-reset addr=80002008 ready_cycle=%0d resp=%0h", obs_done, obs_resp);
        idle_cycle(1'b0, dummy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
